// File: rtl/approx_mul_error_monitor.sv
// approx_mul_error_monitor
// Streaming error-metric accumulator for an approximate multiplier. Each
// accepted sample (in1, in2, approx_prod) is compared with the exact product
// and the error distance ED = |exact - approx| is accumulated over a run of
// sample_limit samples.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse: clear accumulators and (re)start a run
//   sample_limit      samples per run, captured while start is high
//   in_valid/in_ready sample handshake (ready only in RUN)
//   in1, in2          multiplier operands
//   approx_prod       approximate product from the multiplier
//   busy, done        run in progress / run complete (held until next start)
//   sample_cnt        samples accumulated
//   err_cnt           samples with ED != 0
//   ed_sum            saturating sum of ED
//   ed_max            largest ED observed
//
// state | meaning
// IDLE  | waiting for the first start
// RUN   | accepting samples until sample_limit have been taken
// DRAIN | no new samples; pipeline flushing into the accumulators
// DONE  | results stable until the next start
module approx_mul_error_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32,
  parameter int SUM_W = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     sample_limit,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [2*WIDTH-1:0]   approx_prod,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [SUM_W-1:0]     ed_sum,
  output logic [2*WIDTH-1:0]   ed_max
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remain;
  logic             p1_valid, p2_valid;
  logic [PW-1:0]    p1_exact, p1_approx, p2_ed;
  logic             accept;
  logic [PW-1:0]    exact_prod, ed_val;
  logic [SUM_W:0]   sum_wide;

  assign in_ready   = (state == RUN);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  // start wins over acceptance in the same cycle
  assign accept     = in_ready && in_valid && !start;
  assign exact_prod = PW'(in1) * PW'(in2);
  assign ed_val     = (p1_exact >= p1_approx) ? (p1_exact - p1_approx)
                                              : (p1_approx - p1_exact);
  // one extra bit catches the carry used for saturation
  assign sum_wide   = {1'b0, ed_sum} + (SUM_W + 1)'(p2_ed);

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (sample_limit == '0) ? DONE : RUN;
    end else begin
      case (state)
        RUN:     if (accept && remain == CNT_W'(1)) state_nxt = DRAIN;
        // P1 empty means the sample in P2 (if any) is the last one and
        // accumulates on this edge
        DRAIN:   if (!p1_valid) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remain     <= '0;
      p1_valid   <= 1'b0;
      p1_exact   <= '0;
      p1_approx  <= '0;
      p2_valid   <= 1'b0;
      p2_ed      <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        remain     <= sample_limit;
        p1_valid   <= 1'b0;
        p2_valid   <= 1'b0;
        sample_cnt <= '0;
        err_cnt    <= '0;
        ed_sum     <= '0;
        ed_max     <= '0;
      end else begin
        p1_valid  <= accept;
        p1_exact  <= exact_prod;
        p1_approx <= approx_prod;
        p2_valid  <= p1_valid;
        p2_ed     <= ed_val;
        if (accept) remain <= remain - CNT_W'(1);
        if (p2_valid) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          err_cnt    <= err_cnt + CNT_W'(p2_ed != '0);
          ed_sum     <= sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
          if (p2_ed > ed_max) ed_max <= p2_ed;
        end
      end
    end
  end

endmodule
